// File: rtl/display_timings_gen_pkg.sv
// rtl/display_timings_gen_pkg.sv - 480p timing defaults, coordinate type and decode helper
// Purpose: shared constants and helpers for the raster timing generator.
// Ports: none (package).
package display_timings_gen_pkg;

    localparam int DISP_CORDW   = 10;
    localparam int DISP_H_RES   = 640;
    localparam int DISP_H_FP    = 16;
    localparam int DISP_H_SYNC  = 96;
    localparam int DISP_H_BP    = 48;
    localparam int DISP_V_RES   = 480;
    localparam int DISP_V_FP    = 10;
    localparam int DISP_V_SYNC  = 2;
    localparam int DISP_V_BP    = 33;
    localparam int DISP_CLK_DIV = 4;

    localparam int DISP_H_TOTAL = DISP_H_RES + DISP_H_FP + DISP_H_SYNC + DISP_H_BP;
    localparam int DISP_V_TOTAL = DISP_V_RES + DISP_V_FP + DISP_V_SYNC + DISP_V_BP;

    typedef logic [DISP_CORDW-1:0] coord_t;

    // Half-open window test used for sync and data-enable decode.
    function automatic logic in_span(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/display_timings_gen_if.sv
// rtl/display_timings_gen_if.sv - raster output bundle between timing generator and video consumers
// Purpose: carries pixel strobe, coordinates, syncs, data enable, line/frame/animate strobes, frame count.
// Ports: master drives all signals (timing generator); slave receives them (renderer/output stage).
interface display_timings_gen_if
    import display_timings_gen_pkg::*;
#(
    parameter int CORDW = DISP_CORDW
) ();
    logic             pix_en;
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             line_start;
    logic             frame_start;
    logic             animate;
    logic [15:0]      frame_cnt;

    modport master (
        output pix_en, sx, sy, hsync, vsync, de, line_start, frame_start, animate, frame_cnt
    );

    modport slave (
        input pix_en, sx, sy, hsync, vsync, de, line_start, frame_start, animate, frame_cnt
    );
endinterface

// File: rtl/display_timings_gen_clk_en_div.sv
// rtl/display_timings_gen_clk_en_div.sv - system-clock to pixel-enable divider
// Purpose: counts 0..CLK_DIV-1 while en is high and strobes pix_en on the last count.
// Ports: clk, reset_n (async active-low), en (run enable) -> pix_en (one-clk strobe).
module display_timings_gen_clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic pix_en
);
    localparam int              DIVW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    logic [DIVW-1:0] div_q, div_d;
    logic            top_q, top_d;

    // top_q is the registered "div is at its last count" flag; gating it with
    // en keeps pix_en low while frozen and lets it fire straight away on resume
    // if the divider was held on its last count.
    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        top_d = (div_d == DIV_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            top_q <= 1'b0;
        end else begin
            div_q <= div_d;
            top_q <= top_d;
        end
    end

    assign pix_en = en & top_q;

endmodule

// File: rtl/display_timings_gen.sv
// rtl/display_timings_gen.sv - VGA/DVI raster timing generator with pixel-enable divider
// Purpose: raster counters, sync/de decode, line/frame/animate strobes and frame counter.
// Ports: clk, reset_n (async active-low), en (run enable), vid (master: pix_en, sx, sy,
//        hsync, vsync, de, line_start, frame_start, animate, frame_cnt).
module display_timings_gen
    import display_timings_gen_pkg::*;
#(
    parameter int CORDW   = DISP_CORDW,
    parameter int H_RES   = DISP_H_RES,
    parameter int H_FP    = DISP_H_FP,
    parameter int H_SYNC  = DISP_H_SYNC,
    parameter int H_BP    = DISP_H_BP,
    parameter int V_RES   = DISP_V_RES,
    parameter int V_FP    = DISP_V_FP,
    parameter int V_SYNC  = DISP_V_SYNC,
    parameter int V_BP    = DISP_V_BP,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0,
    parameter int CLK_DIV = DISP_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    display_timings_gen_if.master vid
);
    localparam int H_TOTAL  = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_RES + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_RES + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int MAX_LAST = ((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL) - 1;

    typedef logic [CORDW-1:0] crd_t;
    localparam crd_t H_LAST = crd_t'(H_TOTAL - 1);
    localparam crd_t V_LAST = crd_t'(V_TOTAL - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("display_timings_gen: CLK_DIV must be >= 1");
    end
    if ((2 ** CORDW) <= MAX_LAST) begin : g_bad_cordw
        $error("display_timings_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
    end
    if ((H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
        (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_porch
        $error("display_timings_gen: porch and sync widths must be >= 1");
    end

    logic        pix_en;
    crd_t        sx_q, sx_d, sy_q, sy_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        animate_q, animate_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    display_timings_gen_clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .pix_en  (pix_en)
    );

    // Every registered output is decoded from the *next* coordinate, so the
    // syncs, de and strobes line up with the sx/sy they describe.
    always_comb begin
        sx_d          = sx_q;
        sy_d          = sy_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        animate_d     = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        if (pix_en) begin
            if (sx_q == H_LAST) begin
                sx_d = '0;
                sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
            end else begin
                sx_d = sx_q + 1'b1;
            end
            hsync_d       = in_span(int'(sx_d), HS_START, HS_END) ? H_POL : ~H_POL;
            vsync_d       = in_span(int'(sy_d), VS_START, VS_END) ? V_POL : ~V_POL;
            de_d          = in_span(int'(sx_d), 0, H_RES) && in_span(int'(sy_d), 0, V_RES);
            line_start_d  = (sx_d == '0);
            frame_start_d = line_start_d && (sy_d == '0);
            animate_d     = line_start_d && (int'(sy_d) == V_RES);
            if (frame_start_d) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    // Reset parks the raster on the last pixel of the frame so the first
    // pixel enable lands on (0,0) and raises frame_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q          <= H_LAST;
            sy_q          <= V_LAST;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            animate_q     <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            animate_q     <= animate_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vid.pix_en      = pix_en;
    assign vid.sx          = sx_q;
    assign vid.sy          = sy_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.animate     = animate_q;
    assign vid.frame_cnt   = frame_cnt_q;

endmodule
